// File: rtl/riscv_id_ex_stage_if.sv
// Interface between decode, the ID/EX register and the execute ALU.
// Carries decoded fields, forwarding sources, the stall line and EX outputs.
interface riscv_id_ex_stage_if #(
    parameter int XLEN = 64,
    parameter int RW   = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic [RW-1:0]   id_rd;
    logic [1:0]      id_alu_op;
    logic [2:0]      id_funct3;
    logic            id_funct7_30;
    logic            id_alu_src;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_reg_write;
    logic            id_mem_to_reg;
    logic            id_branch;
    logic            flush;
    logic            exm_reg_write;
    logic [RW-1:0]   exm_rd;
    logic [XLEN-1:0] exm_result;
    logic            mwb_reg_write;
    logic [RW-1:0]   mwb_rd;
    logic [XLEN-1:0] mwb_result;

    logic            stall;
    logic            ex_valid;
    logic [3:0]      ex_alu_ctl;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_store_data;
    logic [RW-1:0]   ex_rd;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_reg_write;
    logic            ex_mem_to_reg;
    logic            ex_branch;

    // Upstream/downstream side: drives decode and forwarding, observes EX
    modport master (
        output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_op, id_funct3, id_funct7_30, id_alu_src, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_branch, flush,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        input  stall, ex_valid, ex_alu_ctl, ex_a, ex_b, ex_store_data, ex_rd,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch
    );

    // The ID/EX stage itself
    modport slave (
        input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_op, id_funct3, id_funct7_30, id_alu_src, id_mem_read,
               id_mem_write, id_reg_write, id_mem_to_reg, id_branch, flush,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        output stall, ex_valid, ex_alu_ctl, ex_a, ex_b, ex_store_data, ex_rd,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch
    );
endinterface

// File: rtl/riscv_id_ex_stage.sv
// ID/EX pipeline register for the 64-bit execute ALU.
// Registers decoded fields with the ALU control code pre-decoded, forwards
// EX/MEM and MEM/WB results into the operands, and inserts a bubble with a
// stall toward IF/ID on a load-use hazard.
module riscv_id_ex_stage #(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    riscv_id_ex_stage_if.slave  bus
);

    logic            r_valid;
    logic [3:0]      r_alu_ctl;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;
    logic            r_alu_src;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_reg_write;
    logic            r_mem_to_reg;
    logic            r_branch;

    logic [3:0]      w_alu_ctl;
    logic            w_hazard;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // ALU control decode from alu_op/funct3/funct7[30]; 15 marks an illegal op
    always_comb begin
        w_alu_ctl = 4'd15;
        case (bus.id_alu_op)
            2'b00: w_alu_ctl = 4'd2;
            2'b01: w_alu_ctl = 4'd6;
            default: begin
                case (bus.id_funct3)
                    // Only R-type distinguishes SUB; I-type has no SUBI
                    3'b000:  w_alu_ctl = (bus.id_alu_op == 2'b10 && bus.id_funct7_30) ? 4'd6 : 4'd2;
                    3'b111:  w_alu_ctl = 4'd0;
                    3'b110:  w_alu_ctl = 4'd1;
                    3'b010:  w_alu_ctl = 4'd7;
                    default: w_alu_ctl = 4'd15;
                endcase
            end
        endcase
    end

    // Load-use hazard: both sources compared even if the format lacks one
    always_comb begin
        w_hazard = r_valid && r_mem_read && (r_rd != '0) && bus.id_valid &&
                   ((r_rd == bus.id_rs1) || (r_rd == bus.id_rs2));
    end

    // Pipeline register: reset, then flush, then bubble, then capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_alu_ctl    <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_src    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else if (bus.flush || w_hazard) begin
            // Data fields are left as-is; only validity and controls matter
            r_valid      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else begin
            r_valid      <= bus.id_valid;
            r_alu_ctl    <= w_alu_ctl;
            r_rs1_data   <= bus.id_rs1_data;
            r_rs2_data   <= bus.id_rs2_data;
            r_imm        <= bus.id_imm;
            r_rs1        <= bus.id_rs1;
            r_rs2        <= bus.id_rs2;
            r_rd         <= bus.id_rd;
            r_alu_src    <= bus.id_alu_src;
            r_mem_read   <= bus.id_mem_read;
            r_mem_write  <= bus.id_mem_write;
            r_reg_write  <= bus.id_reg_write;
            r_mem_to_reg <= bus.id_mem_to_reg;
            r_branch     <= bus.id_branch;
        end
    end

    // Operand forwarding: EX/MEM beats MEM/WB, x0 is never forwarded
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == r_rs1))
            w_fwd_rs1 = bus.exm_result;
        else if (bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == r_rs1))
            w_fwd_rs1 = bus.mwb_result;

        w_fwd_rs2 = r_rs2_data;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == r_rs2))
            w_fwd_rs2 = bus.exm_result;
        else if (bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == r_rs2))
            w_fwd_rs2 = bus.mwb_result;
    end

    // Output drive: operands, stall, and controls gated by validity
    always_comb begin
        bus.stall         = w_hazard && !bus.flush;
        bus.ex_valid      = r_valid;
        bus.ex_alu_ctl    = r_alu_ctl;
        bus.ex_a          = w_fwd_rs1;
        bus.ex_b          = r_alu_src ? r_imm : w_fwd_rs2;
        bus.ex_store_data = w_fwd_rs2;
        bus.ex_rd         = r_rd;
        bus.ex_mem_read   = r_mem_read   && r_valid;
        bus.ex_mem_write  = r_mem_write  && r_valid;
        bus.ex_reg_write  = r_reg_write  && r_valid;
        bus.ex_mem_to_reg = r_mem_to_reg && r_valid;
        bus.ex_branch     = r_branch     && r_valid;
    end

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// Directed bench for the ID/EX stage: reset, ALU decode, forwarding,
// load-use bubble, flush and I-type immediates.
module tb_riscv_id_ex_stage;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    riscv_id_ex_stage_if #(.XLEN(64), .RW(5)) bus ();

    riscv_id_ex_stage #(.XLEN(64), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ctrls();
        return {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
                bus.ex_mem_to_reg, bus.ex_branch};
    endfunction

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [63:0] d1, input logic [63:0] d2);
        bus.id_valid      = 1'b1;
        bus.id_alu_op     = op;
        bus.id_funct3     = f3;
        bus.id_funct7_30  = f7;
        bus.id_rs1        = rs1;
        bus.id_rs2        = rs2;
        bus.id_rd         = rd;
        bus.id_rs1_data   = d1;
        bus.id_rs2_data   = d2;
        bus.id_alu_src    = 1'b0;
        bus.id_mem_read   = 1'b0;
        bus.id_mem_write  = 1'b0;
        bus.id_reg_write  = 1'b1;
        bus.id_mem_to_reg = 1'b0;
        bus.id_branch     = 1'b0;
    endtask

    // op, funct3, f7_30, expected ALU control
    logic [9:0] dec_tbl [8] = '{
        {2'b00, 3'b111, 1'b0, 4'd2},
        {2'b01, 3'b000, 1'b1, 4'd6},
        {2'b10, 3'b000, 1'b0, 4'd2},
        {2'b10, 3'b111, 1'b0, 4'd0},
        {2'b10, 3'b110, 1'b1, 4'd1},
        {2'b10, 3'b010, 1'b0, 4'd7},
        {2'b10, 3'b100, 1'b0, 4'd15},
        {2'b11, 3'b111, 1'b0, 4'd0}
    };

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.flush         = 1'b0;
        bus.id_imm        = '0;
        bus.exm_reg_write = 1'b0;
        bus.exm_rd        = '0;
        bus.exm_result    = '0;
        bus.mwb_reg_write = 1'b0;
        bus.mwb_rd        = '0;
        bus.mwb_result    = '0;
        set_instr(2'b10, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 64'd10, 64'd3);
        bus.id_mem_read = 1'b1;
        bus.id_branch   = 1'b1;

        // Reset held two edges with a valid instruction presented
        step();
        step();
        chk("rst_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("rst_ctl",   {60'd0, bus.ex_alu_ctl}, 64'd0);
        chk("rst_ctrls", {59'd0, ctrls()}, 64'd0);
        chk("rst_rd",    {59'd0, bus.ex_rd}, 64'd0);
        chk("rst_a",     bus.ex_a, 64'd0);
        chk("rst_stall", {63'd0, bus.stall}, 64'd0);

        // R-type SUB captured on the first edge after release
        rst_n = 1'b1;
        set_instr(2'b10, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 64'd10, 64'd3);
        step();
        chk("sub_valid", {63'd0, bus.ex_valid}, 64'd1);
        chk("sub_ctl",   {60'd0, bus.ex_alu_ctl}, 64'd6);
        chk("sub_a",     bus.ex_a, 64'd10);
        chk("sub_b",     bus.ex_b, 64'd3);
        chk("sub_sd",    bus.ex_store_data, 64'd3);
        chk("sub_rd",    {59'd0, bus.ex_rd}, 64'd3);
        chk("sub_ctrls", {59'd0, ctrls()}, 64'b00100);

        // ALU decode table
        for (int i = 0; i < 8; i++) begin
            set_instr(dec_tbl[i][9:8], dec_tbl[i][7:5], dec_tbl[i][4], 5'd1, 5'd2, 5'd3, 64'd1, 64'd2);
            step();
            chk($sformatf("dec_%0d", i), {60'd0, bus.ex_alu_ctl}, {60'd0, dec_tbl[i][3:0]});
        end

        // Forwarding priority on rs1 and rs2
        set_instr(2'b10, 3'b000, 1'b0, 5'd5, 5'd6, 5'd9, 64'h11, 64'h22);
        step();
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd5; bus.exm_result = 64'hAA;
        bus.mwb_reg_write = 1'b1; bus.mwb_rd = 5'd5; bus.mwb_result = 64'hBB;
        #1;
        chk("fwd_exm_wins", bus.ex_a, 64'hAA);
        chk("fwd_b_none",   bus.ex_b, 64'h22);
        bus.exm_reg_write = 1'b0;
        #1;
        chk("fwd_mwb",      bus.ex_a, 64'hBB);
        bus.mwb_reg_write = 1'b0;
        #1;
        chk("fwd_none",     bus.ex_a, 64'h11);
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd6; bus.exm_result = 64'hCC;
        #1;
        chk("fwd_rs2_b",    bus.ex_b, 64'hCC);
        chk("fwd_rs2_sd",   bus.ex_store_data, 64'hCC);
        bus.exm_reg_write = 1'b0;
        bus.mwb_reg_write = 1'b1; bus.mwb_rd = 5'd6; bus.mwb_result = 64'hDD;
        #1;
        chk("fwd_rs2_mwb",  bus.ex_store_data, 64'hDD);

        // x0 is never forwarded
        set_instr(2'b10, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9, 64'h33, 64'h44);
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd0;
        bus.mwb_reg_write = 1'b1; bus.mwb_rd = 5'd0;
        step();
        chk("x0_a",  bus.ex_a, 64'h33);
        chk("x0_sd", bus.ex_store_data, 64'h44);
        bus.exm_reg_write = 1'b0;
        bus.mwb_reg_write = 1'b0;

        // Load-use: ld x7 in EX, add reading x7 in ID
        set_instr(2'b00, 3'b011, 1'b0, 5'd2, 5'd0, 5'd7, 64'h100, 64'h0);
        bus.id_mem_read = 1'b1; bus.id_mem_to_reg = 1'b1; bus.id_alu_src = 1'b1;
        bus.id_imm = 64'h8;
        step();
        chk("ld_mem_read", {63'd0, bus.ex_mem_read}, 64'd1);
        chk("ld_b_imm",    bus.ex_b, 64'h8);
        set_instr(2'b10, 3'b000, 1'b0, 5'd1, 5'd7, 5'd8, 64'd5, 64'd6);
        #1;
        chk("lu_stall", {63'd0, bus.stall}, 64'd1);
        step();
        chk("lu_bubble_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("lu_bubble_ctrls", {59'd0, ctrls()}, 64'd0);
        chk("lu_stall_clear",  {63'd0, bus.stall}, 64'd0);
        step();
        chk("lu_cap_valid", {63'd0, bus.ex_valid}, 64'd1);
        chk("lu_cap_rd",    {59'd0, bus.ex_rd}, 64'd8);
        chk("lu_cap_rw",    {63'd0, bus.ex_reg_write}, 64'd1);

        // Flush during a load-use hazard
        set_instr(2'b00, 3'b011, 1'b0, 5'd2, 5'd0, 5'd7, 64'h100, 64'h0);
        bus.id_mem_read = 1'b1; bus.id_mem_to_reg = 1'b1; bus.id_alu_src = 1'b1;
        step();
        set_instr(2'b10, 3'b000, 1'b0, 5'd7, 5'd3, 5'd8, 64'd5, 64'd6);
        bus.id_branch = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", {63'd0, bus.stall}, 64'd0);
        step();
        chk("fl_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("fl_ctrls", {59'd0, ctrls()}, 64'd0);
        bus.flush = 1'b0;

        // id_valid low: EX goes invalid, controls gated off
        set_instr(2'b10, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2);
        bus.id_valid = 1'b0;
        step();
        chk("iv_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("iv_rw",    {63'd0, bus.ex_reg_write}, 64'd0);

        // I-type ADDI with f7_30 set still decodes as ADD
        set_instr(2'b11, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 64'd20, 64'd99);
        bus.id_alu_src = 1'b1;
        bus.id_imm = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        chk("addi_ctl",  {60'd0, bus.ex_alu_ctl}, 64'd2);
        chk("addi_b",    bus.ex_b, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("addi_sd",   bus.ex_store_data, 64'd99);
        bus.id_funct3 = 3'b001;
        step();
        chk("itype_illegal", {60'd0, bus.ex_alu_ctl}, 64'd15);

        // Reset overrides a simultaneous flush/capture
        bus.flush = 1'b1;
        rst_n = 1'b0;
        step();
        chk("rst2_ctl",   {60'd0, bus.ex_alu_ctl}, 64'd0);
        chk("rst2_valid", {63'd0, bus.ex_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
